// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access codes, FSM states,
// byte-offset and byte-enable constants, and the read-data alignment helper.
package lsu_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b011;
  localparam logic [2:0] LHU = 3'b100;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  localparam int         OFF_W   = 2;
  localparam logic [1:0] OFF_0   = 2'b00;

  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    RESP = 2'b10
  } state_t;

  // Right-justify the addressed byte lane of a bus word.
  function automatic logic [31:0] align_rdata(input logic [31:0] d, input logic [OFF_W-1:0] off);
    logic [31:0] r;
    case (off)
      2'd0:    r = d;
      2'd1:    r = {8'h00, d[31:8]};
      2'd2:    r = {16'h0000, d[31:16]};
      2'd3:    r = {24'h000000, d[31:24]};
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/grant/response data-memory bus between the load/store unit
// (master) and the memory system (slave).
interface load_store_unit_if;
  logic        busReq;
  logic        busWe;
  logic [31:0] busAddr;
  logic [3:0]  busBe;
  logic [31:0] busWdata;
  logic        busGnt;
  logic        busRvalid;
  logic [31:0] busRdata;

  modport master (
    output busReq, busWe, busAddr, busBe, busWdata,
    input  busGnt, busRvalid, busRdata
  );

  modport slave (
    input  busReq, busWe, busAddr, busBe, busWdata,
    output busGnt, busRvalid, busRdata
  );
endinterface

// File: rtl/load_store_unit_store_align.sv
// Combinational store alignment: byte enables, replicated write data and the
// misaligned/illegal-request flag for both loads and stores.
module store_align
  import lsu_pkg::*;
(
  input  logic             we,
  input  logic [2:0]       ctrl,
  input  logic [OFF_W-1:0] off,
  input  logic [31:0]      wdata,
  output logic [3:0]       be,
  output logic [31:0]      wdata_rep,
  output logic             bad
);

  // Decode access size into lane enables, data replication and legality.
  always_comb begin
    be        = BE_WORD;
    wdata_rep = 32'h0000_0000;
    bad       = 1'b0;
    if (we) begin
      case (ctrl)
        SB: begin
          be        = BE_BYTE << off;
          wdata_rep = {4{wdata[7:0]}};
        end
        SH: begin
          be        = BE_HALF << off;
          wdata_rep = {2{wdata[15:0]}};
          bad       = off[0];
        end
        SW: begin
          wdata_rep = wdata;
          bad       = (off != OFF_0);
        end
        default: bad = 1'b1;
      endcase
    end else begin
      case (ctrl)
        LB, LBU: bad = 1'b0;
        LH, LHU: bad = off[0];
        LW:      bad = (off != OFF_0);
        default: bad = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: validates one access per request, runs it on the data bus
// with a timeout, and hands right-justified read data to the LoadExt stage.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memReq,
  input  logic        memWrite,
  input  logic [2:0]  lsuCtrl,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        misalign,
  output logic        busErr,
  output logic        lsuDone,
  output logic        loadValid,
  output logic [31:0] dataMem,
  output logic [2:0]  loadCtrlOut,
  load_store_unit_if.master bus
);

  // The counter only needs to reach TIMEOUT_CYC-1: that is the last cycle in a state.
  localparam int             CNT_W    = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [OFF_W-1:0] off_r;
  logic [2:0]       ctrl_r;

  logic [3:0]       be_s;
  logic [31:0]      wdata_rep_s;
  logic             bad_s;
  logic             accept_s;
  logic             reject_s;
  logic             done_s;
  logic             load_done_s;
  logic             err_s;

  store_align u_store_align (
    .we        (memWrite),
    .ctrl      (lsuCtrl),
    .off       (addr[OFF_W-1:0]),
    .wdata     (wdata),
    .be        (be_s),
    .wdata_rep (wdata_rep_s),
    .bad       (bad_s)
  );

  assign accept_s = (state_r == IDLE) && memReq && !bad_s;
  assign reject_s = (state_r == IDLE) && memReq && bad_s;
  assign busy     = (state_r != IDLE) || accept_s;

  // Next-state, timeout counter and completion/error decode.
  always_comb begin
    next_state_s = state_r;
    cnt_nxt_s    = cnt_r + CNT_W'(1);
    done_s       = 1'b0;
    load_done_s  = 1'b0;
    err_s        = 1'b0;
    case (state_r)
      IDLE: begin
        cnt_nxt_s = '0;
        if (accept_s) begin
          next_state_s = REQ;
        end else begin
          next_state_s = IDLE;
        end
      end
      REQ: begin
        if (bus.busGnt) begin
          if (bus.busWe) begin
            next_state_s = IDLE;
            done_s       = 1'b1;
          end else if (bus.busRvalid) begin
            next_state_s = IDLE;
            done_s       = 1'b1;
            load_done_s  = 1'b1;
          end else begin
            next_state_s = RESP;
            cnt_nxt_s    = '0;
          end
        end else if (cnt_r == CNT_LAST) begin
          next_state_s = IDLE;
          err_s        = 1'b1;
        end else begin
          next_state_s = REQ;
        end
      end
      RESP: begin
        if (bus.busRvalid) begin
          next_state_s = IDLE;
          done_s       = 1'b1;
          load_done_s  = 1'b1;
        end else if (cnt_r == CNT_LAST) begin
          next_state_s = IDLE;
          err_s        = 1'b1;
        end else begin
          next_state_s = RESP;
        end
      end
      default: begin
        next_state_s = IDLE;
        cnt_nxt_s    = '0;
      end
    endcase
  end

  // FSM state and timeout counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Registered pulses, latched access fields, bus outputs and load result.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign     <= 1'b0;
      busErr       <= 1'b0;
      lsuDone      <= 1'b0;
      loadValid    <= 1'b0;
      dataMem      <= 32'h0000_0000;
      loadCtrlOut  <= 3'b000;
      off_r        <= '0;
      ctrl_r       <= 3'b000;
      bus.busReq   <= 1'b0;
      bus.busWe    <= 1'b0;
      bus.busAddr  <= 32'h0000_0000;
      bus.busBe    <= 4'b0000;
      bus.busWdata <= 32'h0000_0000;
    end else begin
      misalign   <= reject_s;
      busErr     <= err_s;
      lsuDone    <= done_s;
      loadValid  <= load_done_s;
      bus.busReq <= (next_state_s == REQ);
      if (accept_s) begin
        off_r        <= addr[OFF_W-1:0];
        ctrl_r       <= lsuCtrl;
        bus.busWe    <= memWrite;
        bus.busAddr  <= {addr[31:2], 2'b00};
        bus.busBe    <= be_s;
        bus.busWdata <= wdata_rep_s;
      end
      if (load_done_s) begin
        dataMem     <= align_rdata(bus.busRdata, off_r);
        loadCtrlOut <= ctrl_r;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed scenarios plus randomized
// accesses checked against a size/offset arithmetic reference model.
module tb_load_store_unit;
  localparam int T = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memReq = 1'b0;
  logic        memWrite = 1'b0;
  logic [2:0]  lsuCtrl = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, misalign, busErr, lsuDone, loadValid;
  logic [31:0] dataMem;
  logic [2:0]  loadCtrlOut;

  load_store_unit_if bus ();

  load_store_unit #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .memReq(memReq), .memWrite(memWrite), .lsuCtrl(lsuCtrl),
    .addr(addr), .wdata(wdata), .busy(busy), .misalign(misalign), .busErr(busErr),
    .lsuDone(lsuDone), .loadValid(loadValid), .dataMem(dataMem),
    .loadCtrlOut(loadCtrlOut), .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // pulses = {misalign, busErr, lsuDone, loadValid}
  typedef struct {
    logic [3:0]  pulses;
    logic [31:0] data;
    logic [2:0]  ctrl;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] m_data = 32'h0;
  logic [2:0]  m_ctrl = 3'b000;

  // Monitor: every pulse cycle consumes one expected response.
  always @(negedge clk) begin
    if (misalign || busErr || lsuDone || loadValid) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {28'h0, misalign, busErr, lsuDone, loadValid}, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        chk("pulses", {28'h0, misalign, busErr, lsuDone, loadValid}, {28'h0, mon_e.pulses});
        chk("dataMem", dataMem, mon_e.data);
        chk("loadCtrlOut", {29'h0, loadCtrlOut}, {29'h0, mon_e.ctrl});
        chk("latency", cyc, mon_e.cyc);
      end
    end
  end

  // Reference model: access size in bytes, 0 for an illegal code.
  function automatic int acc_size(input bit we, input logic [2:0] c);
    if (we) return (c == 3'd0) ? 1 : (c == 3'd1) ? 2 : (c == 3'd2) ? 4 : 0;
    return (c == 3'd0 || c == 3'd3) ? 1 : (c == 3'd1 || c == 3'd4) ? 2 : (c == 3'd2) ? 4 : 0;
  endfunction

  function automatic bit is_legal(input bit we, input logic [2:0] c, input logic [31:0] a);
    int s;
    s = acc_size(we, c);
    return (s != 0) && ((int'(a[1:0]) % s) == 0);
  endfunction

  function automatic logic [3:0] exp_be(input bit we, input logic [2:0] c, input logic [31:0] a);
    int s;
    s = acc_size(we, c);
    if (we && s == 1) return 4'(1 << a[1:0]);
    if (we && s == 2) return 4'(3 << a[1:0]);
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wd(input bit we, input logic [2:0] c, input logic [31:0] w);
    int s;
    s = acc_size(we, c);
    if (s == 1) return (w & 32'h0000_00FF) * 32'h0101_0101;
    if (s == 2) return (w & 32'h0000_FFFF) * 32'h0001_0001;
    return w;
  endfunction

  task automatic scramble();
    memReq   = 1'($urandom_range(0, 1));
    memWrite = 1'($urandom_range(0, 1));
    lsuCtrl  = 3'($urandom_range(0, 7));
    addr     = $urandom;
    wdata    = $urandom;
  endtask

  // One access, entered and left at a falling edge. g = cycles before grant,
  // imm = rvalid with grant, r = cycles from grant to rvalid.
  task automatic do_access(input bit we, input logic [2:0] c, input logic [31:0] a,
                           input logic [31:0] w, input logic [31:0] rd,
                           input int g, input bit imm, input int r);
    int          k;
    bit          ok;
    exp_t        e;
    logic [3:0]  be;
    logic [31:0] wd;
    ok = is_legal(we, c, a);
    k  = cyc;
    be = exp_be(we, c, a);
    wd = exp_wd(we, c, w);
    e.data = m_data;
    e.ctrl = m_ctrl;
    if (!ok) begin
      e.pulses = 4'b1000; e.cyc = k + 1;
    end else if (g >= T) begin
      e.pulses = 4'b0100; e.cyc = k + 1 + T;
    end else if (we) begin
      e.pulses = 4'b0010; e.cyc = k + 2 + g;
    end else if (imm || r <= T) begin
      e.pulses = 4'b0011;
      e.cyc    = imm ? k + 2 + g : k + 2 + g + r;
      m_data   = rd >> (8 * a[1:0]);
      m_ctrl   = c;
      e.data   = m_data;
      e.ctrl   = c;
    end else begin
      e.pulses = 4'b0100; e.cyc = k + 2 + g + T;
    end
    sb.push_back(e);
    memReq = 1'b1; memWrite = we; lsuCtrl = c; addr = a; wdata = w;
    #1 chk("busy_req_cycle", {31'h0, busy}, {31'h0, ok});
    if (!ok) begin
      @(negedge clk);
      memReq = 1'b0;
      chk("misalign_no_busreq", {31'h0, bus.busReq}, 32'h0);
      chk("misalign_no_busy", {31'h0, busy}, 32'h0);
      return;
    end
    for (int i = 0; i < T; i++) begin
      @(negedge clk);
      bus.busGnt = 1'b0; bus.busRvalid = 1'b0; bus.busRdata = $urandom;
      scramble();
      chk("busReq_held", {31'h0, bus.busReq}, 32'h1);
      chk("busy_req", {31'h0, busy}, 32'h1);
      chk("busAddr", bus.busAddr, {a[31:2], 2'b00});
      chk("busBe", {28'h0, bus.busBe}, {28'h0, be});
      chk("busWe", {31'h0, bus.busWe}, {31'h0, we});
      if (we) chk("busWdata", bus.busWdata, wd);
      if (i == g) begin
        bus.busGnt = 1'b1;
        if (!we && imm) begin
          bus.busRvalid = 1'b1; bus.busRdata = rd;
        end
        break;
      end
    end
    @(negedge clk);
    bus.busGnt = 1'b0; bus.busRvalid = 1'b0; bus.busRdata = $urandom;
    scramble();
    if (g >= T) begin
      chk("timeout_busreq_drop", {31'h0, bus.busReq}, 32'h0);
      memReq = 1'b0;
      return;
    end
    if (!we && !imm) begin
      for (int j = 1; j <= T; j++) begin
        chk("resp_busy", {31'h0, busy}, 32'h1);
        chk("resp_busreq_low", {31'h0, bus.busReq}, 32'h0);
        if (j == r) begin
          bus.busRvalid = 1'b1; bus.busRdata = rd;
        end
        @(negedge clk);
        bus.busRvalid = 1'b0; bus.busRdata = $urandom;
        scramble();
        if (j == r) break;
      end
    end
    memReq = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    chk({tag, "_pulses"}, {28'h0, misalign, busErr, lsuDone, loadValid}, 32'h0);
    chk({tag, "_dataMem"}, dataMem, 32'h0);
    chk({tag, "_loadCtrlOut"}, {29'h0, loadCtrlOut}, 32'h0);
    chk({tag, "_busReq_busWe"}, {30'h0, bus.busReq, bus.busWe}, 32'h0);
    chk({tag, "_busAddr"}, bus.busAddr, 32'h0);
    chk({tag, "_busBe"}, {28'h0, bus.busBe}, 32'h0);
    chk({tag, "_busWdata"}, bus.busWdata, 32'h0);
  endtask

  initial begin
    bus.busGnt = 1'b0; bus.busRvalid = 1'b0; bus.busRdata = 32'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed scenarios, issued back to back.
    do_access(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80AA_BBCC, 0, 1'b1, 1);
    do_access(1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 0, 1'b0, 1);
    do_access(1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'h0, 0, 1'b0, 1);
    do_access(1'b0, 3'b100, 32'h0000_4002, 32'h0, 32'hCAFE_1234, 5, 1'b0, 3);
    do_access(1'b1, 3'b010, 32'h0000_6000, 32'h1234_5678, 32'h0, T + 3, 1'b0, 1);
    do_access(1'b1, 3'b000, 32'h0000_7001, 32'h0000_00A5, 32'h0, 1, 1'b0, 1);
    do_access(1'b0, 3'b101, 32'h0000_8000, 32'h0, 32'h0, 0, 1'b1, 1);

    // Reset while waiting for read data; a late rvalid must be ignored.
    memReq = 1'b1; memWrite = 1'b0; lsuCtrl = 3'b010; addr = 32'h0000_5000;
    @(negedge clk);
    memReq = 1'b0; bus.busGnt = 1'b1;
    @(negedge clk);
    bus.busGnt = 1'b0;
    chk("resp_before_reset_busy", {31'h0, busy}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("midreset");
    rst = 1'b0; m_data = 32'h0; m_ctrl = 3'b000;
    bus.busRvalid = 1'b1; bus.busRdata = 32'hDEAD_BEEF;
    @(negedge clk);
    bus.busRvalid = 1'b0;
    chk("late_rvalid_idle", {31'h0, busy}, 32'h0);
    chk("late_rvalid_dataMem", dataMem, 32'h0);
    do_access(1'b0, 3'b011, 32'h0000_9002, 32'h0, 32'h11_22_33_44, 2, 1'b1, 1);

    // Randomized accesses with random grant/rvalid delays and idle gaps.
    for (int n = 0; n < 200; n++) begin
      bit          we;
      bit          imm;
      logic [2:0]  c;
      int          g;
      int          r;
      we  = 1'($urandom_range(0, 1));
      imm = 1'($urandom_range(0, 1));
      c   = 3'($urandom_range(0, 5));
      g   = ($urandom_range(0, 11) == 0) ? T + 1 : int'($urandom_range(0, 4));
      r   = ($urandom_range(0, 11) == 0) ? T + 2 : int'($urandom_range(1, T));
      do_access(we, c, $urandom, $urandom, $urandom, g, imm, r);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (T + 5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access unit sitting between the execute stage and the `LoadExt` sign/zero-extension stage. It accepts one load or store per request, checks alignment, and drives a request/grant/response data bus with a word-aligned address, byte enables and replicated write data. Read data is right-justified by byte offset and passed downstream with its load control code. A small FSM tracks each access, stalls the pipeline while an access is outstanding, and enforces a bus timeout.

## Interface
- `TIMEOUT_CYC`, default 255: maximum cycles spent in REQ or RESP before the access is aborted.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `memReq` in 1: access request from execute.
- `memWrite` in 1: 1 means store, 0 means load.
- `lsuCtrl` in 3: load codes LB=000, LH=001, LW=010, LBU=011, LHU=100; store codes SB=000, SH=001, SW=010.
- `addr` in 32: byte address.
- `wdata` in 32: store data, right-justified.
- `busy` out 1: stall request to the pipeline.
- `misalign` out 1: one-cycle pulse; access rejected.
- `busErr` out 1: one-cycle pulse; timeout abort.
- `lsuDone` out 1: one-cycle pulse; access complete.
- `loadValid` out 1: one-cycle pulse; `dataMem` and `loadCtrlOut` are valid.
- `dataMem` out 32: read data shifted right by 8×addr[1:0]; feeds `LoadExt`.
- `loadCtrlOut` out 3: latched `lsuCtrl` of the load; feeds `LoadExt`.
- `busReq`, `busWe` out 1: bus request and write enable.
- `busAddr` out 32: {addr[31:2], 2'b00}.
- `busBe` out 4: byte enables.
- `busWdata` out 32: replicated store data.
- `busGnt`, `busRvalid` in 1: bus grant and read-data valid.
- `busRdata` in 32: bus read data.

## Operation
- FSM states: IDLE, REQ, RESP.
- **IDLE.** `memReq` is sampled.
  - Misaligned or illegal request: `misalign`=1 on the next cycle; no bus access; stay in IDLE.
    - Misaligned: half-word with addr[0]=1, or word with addr[1:0]≠0.
    - Illegal: load code > 100, or store code > 010.
  - Otherwise: latch addr, ctrl, we, be, wdata and go to REQ.
- **REQ.** `busReq`=1 and bus outputs are held stable until `busGnt`.
  - Store granted: go to IDLE; `lsuDone` pulses.
  - Load granted: go to RESP. If `busRvalid` is also high in the same cycle, complete directly: go to IDLE; `loadValid` and `lsuDone` pulse.
- **RESP.** On `busRvalid`, latch `busRdata >> (8*off)` into `dataMem`; `loadValid` and `lsuDone` pulse; go to IDLE.
- **Timeout.** A cycle counter clears on entry to REQ and to RESP. When it reaches `TIMEOUT_CYC`: `busErr` pulses, `busReq` drops, go to IDLE. `dataMem` is not updated.
- **Byte enables.**
  - SB: 0001 << off.
  - SH: 0011 << off.
  - SW, and all loads: 1111.
- **Write data.**
  - SB: {4{wdata[7:0]}}.
  - SH: {2{wdata[15:0]}}.
  - SW: wdata.
- **Busy.** `busy` = (state≠IDLE) OR (IDLE AND `memReq` AND request legal), combinational so the pipeline stalls in the request cycle. `memReq` is ignored outside IDLE.
- **Reset values.** State IDLE, counter 0, every output 0, including `dataMem` and `loadCtrlOut`. Reset mid-access abandons the access; no pulses are emitted.

## Timing
- `busReq` rises the cycle after `memReq` is accepted.
- Best-case load: `memReq` at cycle 0; `busReq`, `busGnt` and `busRvalid` all at cycle 1; `loadValid` at cycle 2.
- Best-case store: `memReq` at cycle 0; `busReq` and `busGnt` at cycle 1; `lsuDone` at cycle 2.
- All pulse outputs are registered and last exactly one cycle.
- `dataMem` and `loadCtrlOut` hold their value until the next completed load.
- Back-to-back accesses: a new request is accepted in the same cycle the state returns to IDLE, i.e. the cycle `lsuDone` is high.
- Timeout fires at exactly `TIMEOUT_CYC` cycles after state entry.

## Structure
- Package `lsu_pkg` holds:
  - load codes LB, LH, LW, LBU, LHU;
  - store codes SB, SH, SW;
  - the state enum IDLE/REQ/RESP;
  - offset and byte-enable constants.
- Sub-module `store_align` (combinational) computes `busBe`, `busWdata` and the misalign/illegal flag from ctrl, we, addr[1:0] and wdata.
- The FSM, counter and read shifter live in the top module.

## Test plan
- LB, addr=0x1003, `busRdata`=0x80AABBCC, immediate grant and rvalid -> `dataMem`=0x00000080, `loadCtrlOut`=000, `loadValid` two cycles after `memReq`.
- SH, addr=0x2002, `wdata`=0x0000BEEF -> `busBe`=1100, `busWdata`=0xBEEFBEEF, `busAddr`=0x2000; `lsuDone` the cycle after `busGnt`.
- LW, addr=0x3001 -> `misalign` pulse; `busReq` stays 0; `busy` stays 0.
- LHU with `busGnt` delayed 5 cycles and `busRvalid` delayed 3 more -> `busy` high throughout, bus outputs stable, exactly one `loadValid`.
- No `busGnt` for `TIMEOUT_CYC` cycles -> `busErr` pulse, return to IDLE, next request served normally.
- `rst` asserted in RESP -> next cycle all outputs 0, state IDLE; a late `busRvalid` is ignored.
